l2_sequencer: RTL and testbench
===============================

# l2_sequencer

Controller that runs one layer-2 inference pass on the 10-wide layer-2 MAC array. On `start` it clears the array, loads the biases, streams 32 hidden activations and their matching weight rows through the array, then runs a sequential argmax over the 10 accumulators. It sits between the layer-1 completion logic and the top-level result/display logic. It owns the MAC control strobes and the shared read address for the hidden-activation buffer and the layer-2 weight ROM.

## Interface
- `N_HIDDEN`, default 32: number of hidden activations streamed per pass.
- `N_OUT`, default 10: number of output neurons / accumulators.
- `ACC_W`, default 20: accumulator width, signed.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `mem_addr`  out  5  shared read address for the hidden buffer and the weight ROM. Both memories have registered reads, so data appears 1 cycle after the address.
- `mac_clr`  out  1  clear strobe to the MAC array.
- `mac_init_bias`  out  1  bias-load strobe to the MAC array.
- `mac_en`  out  1  accumulate strobe to the MAC array.
- `acc_in_packed`  in  N_OUT*ACC_W  packed accumulator outputs from the array; lane j occupies bits [j*ACC_W +: ACC_W].
- `done`  out  1  single-cycle pulse when the result is written.
- `result_class`  out  4  argmax index, 0..9.
- `result_valid`  out  1  result_class holds a valid result.

## Operation
- States: IDLE, CLR, BIAS, MAC, SETTLE, ARGMAX, DONE.
- IDLE: all strobes low. If `start`=1, go to CLR. `start` in any other state is ignored and not queued.
- CLR: `mac_clr`=1 for 1 cycle, then go to BIAS. `result_valid` goes low on entry to CLR.
- BIAS: `mac_init_bias`=1 for 1 cycle with `mem_addr`=0 (prefetch), then go to MAC with k=0.
- MAC: runs 32 cycles, k=0..31.
  - `mac_en`=1 on every cycle.
  - `mem_addr`=min(k+1, 31). On the last cycle the address is held at 31 and the returned data is unused.
  - After k=31, go to SETTLE.
- SETTLE: 1 cycle, strobes low, so the final accumulation is visible on `acc_in_packed`.
- ARGMAX: 10 cycles, index i=0..9.
  - i=0 loads best=lane0 and idx=0.
  - Each later lane is compared signed; update only if strictly greater, so ties resolve to the lowest index.
  - After i=9, go to DONE.
- DONE: `done`=1 and `result_valid`=1, `result_class`=idx. Return to IDLE.
- `result_class` and `result_valid` hold until the next CLR.
- At most one of `mac_clr`, `mac_init_bias`, `mac_en` is high in any cycle.
- Internal counters: k is 6 bits, i is 4 bits. Neither counter wraps; each exit is decoded at the terminal count.

## Timing
- Reset values: state=IDLE, `busy`=0, `mem_addr`=0, `mac_clr`=0, `mac_init_bias`=0, `mac_en`=0, `done`=0, `result_class`=0, `result_valid`=0. Counters and best/idx registers are 0.
- All outputs are registered or decoded from registered state. No combinational path from `acc_in_packed` to any output.
- `start` sampled at cycle T. Then:
  - T+1: CLR.
  - T+2: BIAS.
  - T+3..T+34: MAC.
  - T+35: SETTLE.
  - T+36..T+45: ARGMAX.
  - T+46: DONE, `done` high.
  - Latency from start to done is 46 cycles.
- Back-to-back: a `start` held high is accepted in the IDLE cycle right after DONE, giving one pass every 47 cycles.
- `rst` during any state: on the next edge, all outputs return to their reset values and the pass is abandoned. The MAC array receives no further strobes.

## Configuration
- `L2_SEQ_MAXSCORE_EN` defined: adds output port `max_score` [ACC_W-1:0], signed. It carries the winning accumulator value, updates in DONE, and resets to 0.
- Not defined: the port does not exist and the best-value register is used internally only.
- All other behaviour is identical in both builds.

## Test plan
- Reset then idle: with `start`=0 for 100 cycles, all outputs stay at reset values and `mem_addr`=0.
- Single pass, sequencing: activations=1, lane 7 weights=2, all other weights=1, biases=0.
  - CLR at T+1 and BIAS at T+2.
  - `mac_en` high exactly 32 cycles with `mem_addr` sequence 1..31,31.
  - `done` at T+46, `result_class`=7, `max_score`=64 when the macro is enabled.
- Ties and negatives: lanes 2 and 5 both reach 100 and all others are negative → `result_class`=2. All lanes at -5 → `result_class`=0.
- Start during busy: pulse `start` at T+20 and T+40 → no restart, `done` only at T+46, exactly one pass.
- Reset mid-pass: assert `rst` at T+15.
  - Next cycle: `busy`=0, all strobes 0, `result_valid`=0.
  - A new `start` then completes normally at +46.
- Back-to-back: hold `start` high → `done` pulses 47 cycles apart. `result_valid` drops at each CLR and rises at each DONE.

Source files
------------

// File: rtl/l2_sequencer.sv
// l2_sequencer: clears, bias-loads and streams the layer-2 MAC array, then argmaxes the accumulators.
// Optional `L2_SEQ_MAXSCORE_EN exposes the winning accumulator value on max_score.
module l2_sequencer #(
    parameter int N_HIDDEN = 32,
    parameter int N_OUT    = 10,
    parameter int ACC_W    = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic [4:0]             mem_addr,
    output logic                   mac_clr,
    output logic                   mac_init_bias,
    output logic                   mac_en,
    input  logic [N_OUT*ACC_W-1:0] acc_in_packed,
    output logic                   done,
    output logic [3:0]             result_class,
    output logic                   result_valid
`ifdef L2_SEQ_MAXSCORE_EN
    ,
    output logic signed [ACC_W-1:0] max_score
`endif
);
    typedef enum logic [2:0] {IDLE, CLR, BIAS, MAC, SETTLE, ARGMAX, DONE} state_t;
    state_t state, nxt;
    logic [5:0] k;
    logic [3:0] i, idx;
    logic signed [ACC_W-1:0] best, lane;
    logic signed [ACC_W-1:0] lanes [N_OUT];
    logic take, k_last, i_last;
    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        assign lanes[j] = acc_in_packed[j*ACC_W +: ACC_W];
    end
    assign k_last = k == 6'(N_HIDDEN - 1);
    assign i_last = i == 4'(N_OUT - 1);
    assign busy = state != IDLE;
    assign mac_clr = state == CLR;
    assign mac_init_bias = state == BIAS;
    assign mac_en = state == MAC;
    assign done = state == DONE;
    // The address runs one ahead of k to cover the registered memory read; the last fetch is a don't-care.
    assign mem_addr = (state == MAC) ? (k_last ? 5'(N_HIDDEN - 1) : 5'(k + 6'd1)) : 5'd0;
    always_comb begin
        nxt = state;
        lane = lanes[i];
        take = (i == 4'd0) || (lane > best);
        case (state)
            IDLE:    nxt = start ? CLR : IDLE;
            CLR:     nxt = BIAS;
            BIAS:    nxt = MAC;
            MAC:     nxt = k_last ? SETTLE : MAC;
            SETTLE:  nxt = ARGMAX;
            ARGMAX:  nxt = i_last ? DONE : ARGMAX;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k <= '0;
            i <= '0;
            best <= '0;
            idx <= '0;
            result_class <= '0;
            result_valid <= 1'b0;
`ifdef L2_SEQ_MAXSCORE_EN
            max_score <= '0;
`endif
        end else begin
            state <= nxt;
            k <= (state == MAC) ? k + 6'd1 : 6'd0;
            i <= (state == ARGMAX) ? i + 4'd1 : 4'd0;
            if (state == ARGMAX && take) begin
                best <= lane;
                idx <= i;
            end
            if (state == IDLE && start)
                result_valid <= 1'b0;
            // Fold the last comparison straight into the result so it is valid throughout DONE.
            if (state == ARGMAX && i_last) begin
                result_class <= take ? i : idx;
                result_valid <= 1'b1;
`ifdef L2_SEQ_MAXSCORE_EN
                max_score <= take ? lane : best;
`endif
            end
        end
    end
endmodule

// File: tb/tb_l2_sequencer.sv
// tb_l2_sequencer: randomized scoreboard bench with a behavioural MAC array and argmax reference model.
module tb_l2_sequencer;
    localparam int NH = 32;
    localparam int NO = 10;
    localparam int AW = 20;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic busy, mac_clr, mac_init_bias, mac_en, done, result_valid;
    logic [4:0] mem_addr;
    logic [3:0] result_class;
    logic [NO*AW-1:0] acc_pk;
`ifdef L2_SEQ_MAXSCORE_EN
    logic signed [AW-1:0] max_score;
`endif
    l2_sequencer #(.N_HIDDEN(NH), .N_OUT(NO), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .mem_addr(mem_addr),
        .mac_clr(mac_clr), .mac_init_bias(mac_init_bias), .mac_en(mac_en),
        .acc_in_packed(acc_pk), .done(done), .result_class(result_class),
        .result_valid(result_valid)
`ifdef L2_SEQ_MAXSCORE_EN
        , .max_score(max_score)
`endif
    );
    always #5 clk = ~clk;
    int act [NH];
    int w [NH][NO];
    int bias [NO];
    int act_q;
    int w_q [NO];
    int acc [NO];
    always @(posedge clk) begin
        act_q <= act[mem_addr];
        for (int j = 0; j < NO; j++) begin
            w_q[j] <= w[mem_addr][j];
            if (mac_clr) acc[j] <= 0;
            else if (mac_init_bias) acc[j] <= bias[j];
            else if (mac_en) acc[j] <= acc[j] + act_q * w_q[j];
        end
    end
    always_comb begin
        acc_pk = '0;
        for (int j = 0; j < NO; j++) acc_pk[j*AW +: AW] = acc[j][AW-1:0];
    end
    typedef struct {int cls; int score; int cyc;} exp_t;
    exp_t q[$];
    int cyc = 0, next_free = 0, checks = 0, errors = 0, exp_class = 0;
    logic exp_valid = 1'b0;
    function automatic exp_t model();
        exp_t e;
        int s;
        e.cls = 0;
        e.score = 0;
        e.cyc = 0;
        for (int j = 0; j < NO; j++) begin
            s = bias[j];
            for (int n = 0; n < NH; n++) s += act[n] * w[n][j];
            if (j == 0 || s > e.score) begin
                e.score = s;
                e.cls = j;
            end
        end
        return e;
    endfunction
    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, want, cyc);
        end
    endtask
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            next_free = cyc + 1;
            exp_valid = 1'b0;
            exp_class = 0;
        end else if (start && cyc >= next_free) begin
            e = model();
            e.cyc = cyc + 46;
            q.push_back(e);
            next_free = cyc + 47;
            exp_valid = 1'b0;
        end
        cyc = cyc + 1;
        if (!rst && q.size() > 0 && cyc == q[0].cyc) begin
            exp_valid = 1'b1;
            exp_class = q[0].cls;
        end
    end
    always @(negedge clk) begin
        int off, addr;
        logic en;
        logic [10:0] want;
        exp_t e;
        off = (cyc < next_free) ? cyc - (next_free - 47) : 0;
        en = off >= 3 && off <= 34;
        addr = en ? ((off - 2 > 31) ? 31 : off - 2) : 0;
        want = {off != 0, off == 1, off == 2, en, 5'(addr), off == 46};
        check("ctrl", int'({busy, mac_clr, mac_init_bias, mac_en, mem_addr, done}), int'(want));
        check("result", int'({result_valid, result_class}), int'({exp_valid, exp_class[3:0]}));
        if (done) begin
            if (q.size() == 0) check("done_unexpected", 1, 0);
            else begin
                e = q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("class", int'(result_class), e.cls);
`ifdef L2_SEQ_MAXSCORE_EN
                check("max_score", int'(max_score), e.score);
`endif
            end
        end
    end
    task automatic pass_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (50) @(negedge clk);
    endtask
    task automatic fill_random(input int bmin, input int bmax);
        for (int n = 0; n < NH; n++) begin
            act[n] = int'($urandom_range(15));
            for (int j = 0; j < NO; j++) w[n][j] = int'($urandom_range(15)) - 8;
        end
        for (int j = 0; j < NO; j++) bias[j] = bmin + int'($urandom_range(bmax - bmin));
    endtask
    initial begin
        for (int n = 0; n < NH; n++) begin
            act[n] = 1;
            for (int j = 0; j < NO; j++) w[n][j] = (j == 7) ? 2 : 1;
        end
        for (int j = 0; j < NO; j++) bias[j] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        pass_run();
        fill_random(-100, -1);
        for (int n = 0; n < NH; n++) act[n] = 0;
        bias[2] = 100;
        bias[5] = 100;
        pass_run();
        for (int j = 0; j < NO; j++) bias[j] = -5;
        pass_run();
        fill_random(-500, 500);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (18) @(negedge clk) start = 1'b0;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (19) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        fill_random(-500, 500);
        pass_run();
        start = 1'b1;
        repeat (47 * 3) @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        for (int p = 0; p < 20; p++) begin
            fill_random(-500, 500);
            pass_run();
        end
        check("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
